// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory bus bundle for mem_port_arbiter
// Purpose: carries the fetch request/ack, data request/ack and unified memory
//          port handshakes between the arbiter and its environment.
// Signals: ins_req/ins_addr -> ins_ack/ins_rdata      (fetch path)
//          data_req/data_we/data_addr/data_wdata -> data_ack/data_rdata
//          mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata
// Modports: master = requesters plus backing memory, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ins_req;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_ack;
  logic [DATA_W-1:0] ins_rdata;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output ins_req, ins_addr, data_req, data_we, data_addr, data_wdata,
           mem_ack, mem_rdata,
    input  ins_ack, ins_rdata, data_ack, data_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ins_req, ins_addr, data_req, data_we, data_addr, data_wdata,
           mem_ack, mem_rdata,
    output ins_ack, ins_rdata, data_ack, data_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter onto one memory port
// Purpose: shares a single variable-latency memory port between the fetch
//          and data paths; alternates grants under contention.
// Ports:   clock, reset_n (synchronous, active low)
//          bus   : mem_port_arbiter_if.slave (fetch, data and memory handshakes)
//          busy  : high while a transaction is in ISSUE or RESP
//          error : sticky timeout flag
// Option:  MEM_ARB_TIMEOUT_EN enables the ISSUE timeout of TIMEOUT_CYCLES
//          cycles; without it ISSUE waits forever and error is 0.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              error
);

  // The timeout counter is 8 bits wide, so only 1..255 is meaningful.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gTimeoutRange
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            nextState;
  logic              grant;
  logic              grantData;     // 1 = data path wins this grant
  logic              ownerData;     // owner of the transaction in flight
  logic              lastOwnerData; // owner of the last completed transaction
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] insRdata;
  logic [DATA_W-1:0] dataRdata;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] waitCount;
  logic       timeoutHit;
  logic       errorFlag;

  // A same-cycle mem_ack beats the count match.
  assign timeoutHit = (state == ISSUE) && !bus.mem_ack &&
                      (waitCount == 8'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    grant     = 1'b0;
    grantData = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ins_req || bus.data_req) begin
          grant = 1'b1;
          // Under contention the side that was not served last wins.
          grantData = bus.data_req && (!bus.ins_req || !lastOwnerData);
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ack) nextState = RESP;
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeoutHit) nextState = RESP;
`endif
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ownerData     <= 1'b0;
      lastOwnerData <= 1'b1;
      memWe         <= 1'b0;
      memAddr       <= '0;
      memWdata      <= '0;
      insRdata      <= '0;
      dataRdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      waitCount     <= 8'd0;
      errorFlag     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            ownerData <= grantData;
            memAddr   <= grantData ? bus.data_addr : bus.ins_addr;
            memWe     <= grantData && bus.data_we;
            memWdata  <= grantData ? bus.data_wdata : '0;
`ifdef MEM_ARB_TIMEOUT_EN
            waitCount <= 8'd0;
`endif
          end
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            // Captured even on writes; the requester ignores it then.
            if (ownerData) dataRdata <= bus.mem_rdata;
            else           insRdata  <= bus.mem_rdata;
            lastOwnerData <= ownerData;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timeoutHit) begin
            if (ownerData) dataRdata <= DATA_W'(32'hDEADBEEF);
            else           insRdata  <= DATA_W'(32'hDEADBEEF);
            lastOwnerData <= ownerData;
            errorFlag     <= 1'b1;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Every output is a register or a decode of registered state only.
  assign bus.mem_req    = (state == ISSUE);
  assign bus.mem_we     = memWe;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;
  assign bus.ins_ack    = (state == RESP) && !ownerData;
  assign bus.data_ack   = (state == RESP) && ownerData;
  assign bus.ins_rdata  = insRdata;
  assign bus.data_rdata = dataRdata;
  assign busy           = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  assign error = errorFlag;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Purpose: table vectors, randomized transactions against a reference model,
//          and hand-written contention, reset and timeout sequences.
// Ports:   none (top-level bench); drives the arbiter through its interface.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  logic error;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          insReq;
    bit          dataReq;
    bit          dataWe;
    bit          dropReq;
    logic [31:0] insAddr;
    logic [31:0] dataAddr;
    logic [31:0] dataWdata;
    logic [31:0] memData;
    int          waits;
    bit          expData;
    logic [31:0] expAddr;
    bit          expWe;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Memory model state
  int          memWaits    = 0;
  bit          memNoAck    = 1'b0;
  bit          memUseFixed = 1'b0;
  logic [31:0] memData     = 32'h0;
  int          waitCnt     = 0;

  // Reference model: which side was served most recently (1 = data).
  bit modelLastData = 1'b1;

  function automatic logic [31:0] memFunc(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Backing memory: acks after memWaits wait cycles while mem_req is high.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (bus.mem_req === 1'b1 && !memNoAck) begin
        if (waitCnt >= memWaits) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = memUseFixed ? memData : memFunc(bus.mem_addr);
          waitCnt       = 0;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
          waitCnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        waitCnt     = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic doReset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    modelLastData = 1'b1;
  endtask

  task automatic runTxn(input vec_t v, input string tag);
    int          cyc;
    int          issueCyc;
    bit          gotAck;
    bit          stableOk;
    bit          insAck;
    bit          dataAck;
    logic [31:0] insR;
    logic [31:0] dataR;
    cyc = 0; issueCyc = 0; gotAck = 0; stableOk = 1;
    insAck = 0; dataAck = 0; insR = 0; dataR = 0;
    @(negedge clock);
    bus.ins_req    = v.insReq;
    bus.ins_addr   = v.insAddr;
    bus.data_req   = v.dataReq;
    bus.data_we    = v.dataWe;
    bus.data_addr  = v.dataAddr;
    bus.data_wdata = v.dataWdata;
    memWaits       = v.waits;
    memData        = v.memData;
    while (!gotAck && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (bus.mem_req) begin
        issueCyc++;
        if (bus.mem_addr !== v.expAddr || bus.mem_we !== v.expWe ||
            (v.expWe && bus.mem_wdata !== v.expWdata)) stableOk = 0;
        if (issueCyc == 1) begin
          // Post-grant changes must not reach the memory port.
          bus.ins_addr   = $urandom;
          bus.data_addr  = $urandom;
          bus.data_wdata = $urandom;
          bus.data_we    = $urandom_range(0, 1);
          if (v.dropReq) begin
            bus.ins_req  = 1'b0;
            bus.data_req = 1'b0;
          end
        end
      end
      if (bus.ins_ack || bus.data_ack) begin
        gotAck  = 1;
        insAck  = bus.ins_ack;
        dataAck = bus.data_ack;
        insR    = bus.ins_rdata;
        dataR   = bus.data_rdata;
        bus.ins_req  = 1'b0;
        bus.data_req = 1'b0;
      end
    end
    chk({tag, "_ack_seen"}, gotAck, 1);
    if (gotAck) begin
      chk({tag, "_latency"}, cyc, v.waits + 2);
      chk({tag, "_issue_cycles"}, issueCyc, v.waits + 1);
      chk({tag, "_ins_ack"}, insAck, !v.expData);
      chk({tag, "_data_ack"}, dataAck, v.expData);
      if (!v.expWe) chk({tag, "_rdata"}, v.expData ? dataR : insR, v.expRdata);
      chk({tag, "_mem_stable"}, stableOk, 1);
      @(negedge clock);
      chk({tag, "_ack_pulse"}, {bus.ins_ack, bus.data_ack}, 2'b00);
      chk({tag, "_busy_idle"}, busy, 0);
    end
    modelLastData = v.expData;
  endtask

  vec_t        tbl[6];
  vec_t        v;
  bit          winData;
  int          ackCount;
  int          lastAckCyc;
  bit          prevAny;
  bit          got;
  logic [31:0] insR;
  int          n;

  initial begin
    bus.ins_req = 0; bus.ins_addr = 0; bus.data_req = 0; bus.data_we = 0;
    bus.data_addr = 0; bus.data_wdata = 0;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00400000, 32'h0, 32'h0, 32'h012a5820,
               0, 1'b0, 32'h00400000, 1'b0, 32'h0, 32'h012a5820};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h10010004, 32'h12345678, 32'hCAFEF00D,
               3, 1'b1, 32'h10010004, 1'b1, 32'h12345678, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10010008, 32'h0, 32'h0BADF00D,
               1, 1'b1, 32'h10010008, 1'b0, 32'h0, 32'h0BADF00D};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00400004, 32'h0, 32'h0, 32'h8FBF0010,
               2, 1'b0, 32'h00400004, 1'b0, 32'h0, 32'h8FBF0010};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h7FFFFFFC, 32'h55555555, 32'hFFFFFFFF,
               0, 1'b1, 32'h7FFFFFFC, 1'b0, 32'h55555555, 32'hFFFFFFFF};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00400008, 32'h0, 32'h0, 32'h00000000,
               5, 1'b0, 32'h00400008, 1'b0, 32'h0, 32'h00000000};

    doReset();
    @(negedge clock);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_acks", {bus.ins_ack, bus.data_ack}, 2'b00);
    chk("rst_rdata", {bus.ins_rdata, bus.data_rdata}, 64'h0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);

    memUseFixed = 1'b1;
    for (int i = 0; i < 6; i++) runTxn(tbl[i], $sformatf("tbl%0d", i));

    memUseFixed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v.insReq    = $urandom_range(0, 1);
      v.dataReq   = $urandom_range(0, 1);
      if (!v.insReq && !v.dataReq) v.dataReq = 1'b1;
      v.dataWe    = $urandom_range(0, 1);
      v.dropReq   = $urandom_range(0, 1);
      v.insAddr   = $urandom;
      v.dataAddr  = $urandom;
      v.dataWdata = $urandom;
      v.memData   = 32'h0;
      v.waits     = $urandom_range(0, 3);
      // Lone requester wins; under contention the side not served last wins.
      if (v.insReq && v.dataReq) winData = !modelLastData;
      else                       winData = v.dataReq;
      v.expData  = winData;
      v.expAddr  = winData ? v.dataAddr : v.insAddr;
      v.expWe    = winData && v.dataWe;
      v.expWdata = v.dataWdata;
      v.expRdata = memFunc(v.expAddr);
      runTxn(v, $sformatf("rnd%0d", i));
    end

    // Contention from reset: ins, data, ins, data, one every 3 cycles.
    bus.ins_req = 1; bus.ins_addr = 32'h00401000;
    bus.data_req = 1; bus.data_we = 0; bus.data_addr = 32'h10020000;
    memWaits = 0;
    doReset();
    ackCount = 0; lastAckCyc = 0; prevAny = 0;
    for (int c = 1; c <= 60 && ackCount < 4; c++) begin
      @(negedge clock);
      if (bus.ins_ack || bus.data_ack) begin
        chk($sformatf("cont%0d_owner", ackCount), {bus.ins_ack, bus.data_ack},
            (ackCount % 2 == 0) ? 2'b10 : 2'b01);
        chk($sformatf("cont%0d_rdata", ackCount),
            (ackCount % 2 == 0) ? bus.ins_rdata : bus.data_rdata,
            (ackCount % 2 == 0) ? memFunc(32'h00401000) : memFunc(32'h10020000));
        chk($sformatf("cont%0d_pulse", ackCount), prevAny, 0);
        if (ackCount > 0) chk($sformatf("cont%0d_gap", ackCount), c - lastAckCyc, 3);
        lastAckCyc = c;
        ackCount++;
        if (ackCount == 4) begin bus.ins_req = 0; bus.data_req = 0; end
        prevAny = 1;
      end else begin
        prevAny = 0;
      end
    end
    chk("cont_count", ackCount, 4);
    repeat (3) @(negedge clock);

    // Reset in the middle of ISSUE.
    @(negedge clock);
    bus.ins_req = 1; bus.ins_addr = 32'h00400100; memWaits = 20;
    n = 0;
    while (!bus.mem_req && n < 10) begin @(negedge clock); n++; end
    chk("rstmid_issue", bus.mem_req, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b0; bus.ins_req = 0;
    @(negedge clock);
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_acks", {bus.ins_ack, bus.data_ack}, 2'b00);
    chk("rstmid_mem_addr", bus.mem_addr, 0);
    chk("rstmid_rdata", {bus.ins_rdata, bus.data_rdata}, 64'h0);
    reset_n = 1'b1; modelLastData = 1'b1;
    memUseFixed = 1'b1;
    runTxn(tbl[0], "rstmid_fetch");

    // Memory that never acknowledges.
    doReset();
    memNoAck = 1'b1;
    @(negedge clock);
    bus.ins_req = 1; bus.ins_addr = 32'h00400200;
    got = 0; insR = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clock);
      if (bus.ins_ack) begin
        got = 1; insR = bus.ins_rdata; bus.ins_req = 0;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    chk("tmo_ack", got, 1);
    chk("tmo_rdata", insR, 32'hDEADBEEF);
    repeat (3) @(negedge clock);
    chk("tmo_error", error, 1);
    chk("tmo_busy", busy, 0);
`else
    chk("tmo_ack", got, 0);
    chk("tmo_mem_req", bus.mem_req, 1);
    chk("tmo_error", error, 0);
`endif
    bus.ins_req = 0; memNoAck = 1'b0;
    doReset();
    @(negedge clock);
    chk("tmo_error_cleared", error, 0);
    chk("tmo_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one unified memory port between the CPU instruction-fetch path and the CPU data path. It sits between the core's fetch/load-store interfaces and the single backing memory, so the split instruction/data memory can be replaced by one memory with variable latency. Service alternates round-robin when both requesters contend. Every transaction completes through a registered request/acknowledge handshake.

## Interface
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width for all ports
- TIMEOUT_CYCLES, 255, maximum ISSUE cycles before abort (used only with MEM_ARB_TIMEOUT_EN); 8-bit counter, legal range 1–255
- clock  in  1  system clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- ins_req  in  1  fetch request (level, held until ins_ack)
- ins_addr  in  ADDR_W  fetch address
- ins_ack  out  1  one-cycle completion pulse to fetch
- ins_rdata  out  DATA_W  fetched word, valid while ins_ack=1
- data_req  in  1  data request (level, held until data_ack)
- data_we  in  1  1=write, 0=read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_ack  out  1  one-cycle completion pulse to data path
- data_rdata  out  DATA_W  load word, valid while data_ack=1
- mem_req  out  1  request to memory, held until mem_ack
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  registered address to memory
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  memory completion (read data valid same cycle)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in ISSUE or RESP
- error  out  1  sticky timeout flag (tied 0 without MEM_ARB_TIMEOUT_EN)

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE behaviour:
  - Neither req: stay.
  - One req: grant it.
  - Both: grant the requester not served last (last_owner register).
  - On grant: latch owner, address, we (0 for ins) and wdata into mem_* registers, then go to ISSUE.
- ISSUE:
  - mem_req=1, mem_* stable.
  - On mem_ack=1: capture mem_rdata into the owner's rdata register, set last_owner=owner, go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle, then IDLE.
  - The other requester's ack stays 0.
  - Its rdata register holds its last value.
- Requests are sampled only in IDLE. A req still high in the IDLE cycle after RESP counts as a new request.
- A requester dropping req mid-transaction does not cancel it. The transaction completes and the ack pulse still fires.
- Address, wdata and we changes after grant are ignored.
- mem_ack outside ISSUE is ignored.
- Writes: mem_rdata is captured regardless of we. Rdata content on a write ack is don't-care.
- Reset (any state, including mid-transaction) puts the following into effect at the next edge:
  - state=IDLE
  - mem_req=mem_we=0
  - mem_addr=mem_wdata=0
  - ins_ack=data_ack=0
  - ins_rdata=data_rdata=0
  - busy=0, error=0
  - last_owner=data, so fetch wins the first contention
- Any pending memory transaction is abandoned. Memory must tolerate mem_req dropping.

## Timing
- Cycle k = period following rising edge k.
- Minimum latency for a req asserted in IDLE cycle 0:
  - Edge 1 enters ISSUE; mem_req=1 in cycle 1.
  - mem_ack=1 in cycle 1 means edge 2 enters RESP; ack=1 in cycle 2.
  - Result: 2 cycles from req to ack.
- Each extra mem_ack wait cycle adds exactly one cycle.
- Back-to-back transactions: at least one IDLE cycle between RESP and the next ISSUE, so peak throughput is one transaction per 3 cycles.
- All outputs are registered. No combinational path runs from any input to any output.

## Configuration
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering ISSUE and increments each ISSUE cycle without mem_ack.
  - If the count equals TIMEOUT_CYCLES and mem_ack=0, the arbiter goes to RESP, drops mem_req at that edge and loads the owner's rdata with 32'hDEADBEEF.
  - error is set and stays set until reset.
  - mem_ack arriving in the same cycle as the count match wins: normal completion, no error.
- Undefined:
  - No counter; ISSUE waits indefinitely.
  - error is constant 0.

## Test plan
- Reset then single fetch: ins_req=1, ins_addr=0x00400000; memory returns 0x012a5820 with 0-wait mem_ack.
  - mem_req high in cycle 1, mem_addr=0x00400000, mem_we=0.
  - ins_ack pulse in cycle 2 with ins_rdata=0x012a5820.
  - data_ack stays 0.
- Data write: data_we=1, data_addr=0x10010004, data_wdata=0x12345678, 3 wait cycles.
  - mem_we=1 and mem_wdata=0x12345678 held for 4 cycles.
  - data_ack exactly 4 cycles after ISSUE entry plus one.
- Contention: ins_req and data_req both held high from reset for 4 transactions.
  - Grants alternate ins, data, ins, data.
  - Each ack is a single-cycle pulse.
- Reset mid-transaction: assert reset_n=0 during ISSUE after 2 wait cycles.
  - Next edge: mem_req=0, busy=0, no ack.
  - After release, a fresh fetch completes normally.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): memory never acks.
  - ins_ack with ins_rdata=0xDEADBEEF.
  - error=1, held until reset.
  - Without the macro the same stimulus leaves mem_req high indefinitely and error=0.
